// File: rtl/narvie_uart_pkg.sv
// Shared constants and state encoding for the narvie UART link (tx and rx sides).
`default_nettype none

package narvie_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 104;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser. A start request during the last stop-bit cycle
// chains straight into the next start bit, so consecutive bytes have no gap.
`default_nettype none

module uart_tx_byte
  import narvie_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk12,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             tx_n;
  logic             tick;

  assign tick = (baud_cnt == CNT_LAST);
  assign busy = (state != IDLE);
  assign done = (state == STOP) && tick;

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = tick ? '0 : baud_cnt + CNT_W'(1);
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    tx_n       = tx;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        if (start) begin
          state_n   = START;
          shift_n   = data;
          bit_idx_n = '0;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (tick) begin
          // Chaining here rather than via IDLE is what removes the inter-byte gap.
          if (start) begin
            state_n   = START;
            shift_n   = data;
            bit_idx_n = '0;
            tx_n      = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tx_word.sv
// Word-level UART transmitter: sends a 32-bit word as four 8N1 frames, LSB byte first.
`default_nettype none

module tx_word
  import narvie_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk12,
  input  logic        rst,
  input  logic [31:0] word,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        word_sent
);

  logic        accept;
  logic        last_byte;
  logic        byte_start;
  logic        byte_busy;
  logic        byte_done;
  logic [7:0]  byte_data;
  logic [31:0] shreg;
  logic [1:0]  byte_idx;

  assign accept     = word_valid && word_ready && !byte_busy;
  assign last_byte  = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign byte_start = accept || (byte_done && !last_byte);
  // Byte0 bypasses the shift register so START begins on the edge after accept.
  assign byte_data  = accept ? word[7:0] : shreg[15:8];

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      byte_idx   <= '0;
      word_ready <= 1'b1;
      word_sent  <= 1'b0;
    end else begin
      word_sent <= byte_done && last_byte;
      if (accept) begin
        shreg      <= word;
        byte_idx   <= '0;
        word_ready <= 1'b0;
      end else if (byte_done) begin
        shreg    <= {8'h00, shreg[31:8]};
        byte_idx <= byte_idx + 2'd1;
        if (last_byte) begin
          word_ready <= 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk12 (clk12),
    .rst   (rst),
    .start (byte_start),
    .data  (byte_data),
    .busy  (byte_busy),
    .done  (byte_done),
    .tx    (tx)
  );

endmodule

`default_nettype wire

// File: tb/tb_tx_word.sv
// Bench for tx_word at CLKS_PER_BIT = 4: table vectors, corner sequences, random words.
`default_nettype none

module tb_tx_word;

  localparam int CPB  = 4;
  localparam int WLEN = 40 * CPB;

  logic        clk12 = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] word  = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        tx;
  logic        word_sent;

  int applied     = 0;
  int miscompares = 0;

  tx_word #(.CLKS_PER_BIT(CPB)) dut (
    .clk12      (clk12),
    .rst        (rst),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx         (tx),
    .word_sent  (word_sent)
  );

  always #5 clk12 = ~clk12;

  typedef struct {
    logic [31:0] w;
    logic [31:0] after_w;
    logic        after_v;
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ideal line waveform for one word: each byte framed {stop, data, start}, each bit CPB cycles.
  function automatic logic [WLEN-1:0] model_wave(input logic [31:0] w);
    logic [WLEN-1:0] r;
    logic [9:0]      frame;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      frame = {1'b1, w[8*b +: 8], 1'b0};
      for (int j = 0; j < 10; j++)
        for (int c = 0; c < CPB; c++)
          r[b*40 + j*CPB + c] = frame[j];
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the word_sent cycle.
  task automatic xfer(input string nm, input logic [31:0] w, input logic [31:0] after_w,
                      input logic after_v, input logic [7:0] e0, e1, e2, e3);
    logic [WLEN-1:0] wave;
    logic [WLEN-1:0] exp_wave;
    logic [7:0]      got [4];
    logic [7:0]      exp [4];
    int ready_hi, sent_hi;
    ready_hi = 0;
    sent_hi  = 0;
    exp = '{e0, e1, e2, e3};
    chk({nm, " ready_before"}, {31'd0, word_ready}, 32'd1);
    word = w;
    word_valid = 1'b1;
    @(posedge clk12);
    @(negedge clk12);
    word = after_w;
    word_valid = after_v;
    for (int i = 0; i <= WLEN; i++) begin
      if (i > 0) @(negedge clk12);
      if (i < WLEN) begin
        wave[i] = tx;
        if (word_ready) ready_hi++;
        if (word_sent)  sent_hi++;
      end
    end
    chk({nm, " sent_at_161"},  {31'd0, word_sent},  32'd1);
    chk({nm, " ready_at_161"}, {31'd0, word_ready}, 32'd1);
    chk({nm, " tx_idle_161"},  {31'd0, tx},         32'd1);
    chk({nm, " ready_low_cycles"}, ready_hi, 0);
    chk({nm, " sent_early"},       sent_hi,  0);
    exp_wave = model_wave(w);
    applied++;
    if (wave !== exp_wave) begin
      miscompares++;
      $display("FAIL %s waveform: got %h expected %h", nm, wave, exp_wave);
    end
    for (int b = 0; b < 4; b++) begin
      for (int d = 0; d < 8; d++) got[b][d] = wave[b*40 + (d+1)*CPB + CPB/2];
      chk($sformatf("%s byte%0d", nm, b), {24'd0, got[b]}, {24'd0, exp[b]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur, nxt;
    logic        v;

    tbl[0] = '{32'h1234_5678, 32'h0,         1'b0, 8'h78, 8'h56, 8'h34, 8'h12};
    tbl[1] = '{32'hA5A5_0000, 32'hFFFF_FFFF, 1'b1, 8'h00, 8'h00, 8'hA5, 8'hA5};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0,         1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[3] = '{32'h0000_00C3, 32'hDEAD_BEEF, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h00};
    tbl[4] = '{32'hDEAD_BEEF, 32'h0,         1'b0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tbl[5] = '{32'h0000_0000, 32'h0,         1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{32'hFFFF_FFFF, 32'h0,         1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset state and quiet idle.
    @(negedge clk12);
    chk("reset tx",    {31'd0, tx},         32'd1);
    chk("reset ready", {31'd0, word_ready}, 32'd1);
    chk("reset sent",  {31'd0, word_sent},  32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk12);
      chk($sformatf("idle%0d", i), {29'd0, tx, word_ready, word_sent}, {29'd0, 3'b110});
    end

    for (int k = 0; k < 7; k++)
      xfer($sformatf("tbl%0d", k), tbl[k].w, tbl[k].after_w, tbl[k].after_v,
           tbl[k].e0, tbl[k].e1, tbl[k].e2, tbl[k].e3);

    // Reset asserted between edges during data bit 3 of byte1.
    word = 32'hCAFE_1234;
    word_valid = 1'b1;
    @(posedge clk12);
    @(negedge clk12);
    word_valid = 1'b0;
    repeat (56) @(negedge clk12);
    chk("pre_reset tx_is_bit3", {31'd0, tx}, {31'd0, word[11]});
    #2 rst = 1'b1;
    #1;
    chk("midreset tx",    {31'd0, tx},         32'd1);
    chk("midreset ready", {31'd0, word_ready}, 32'd1);
    chk("midreset sent",  {31'd0, word_sent},  32'd0);
    @(negedge clk12);
    rst = 1'b0;
    @(negedge clk12);
    xfer("post_reset", 32'h0102_0304, 32'h0, 1'b0, 8'h04, 8'h03, 8'h02, 8'h01);

    // Random words; random back-to-back chaining via a held word_valid.
    cur = $urandom;
    for (int r = 0; r < 16; r++) begin
      nxt = $urandom;
      v   = 1'($urandom_range(0, 1));
      xfer($sformatf("rnd%0d", r), cur, nxt, v, cur[7:0], cur[15:8], cur[23:16], cur[31:24]);
      cur = nxt;
    end
    word_valid = 1'b0;
    repeat (4) @(negedge clk12);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
